// File: rtl/ram_port_arbiter_if.sv
// ============================================================================
// ram_port_arbiter_if : request/ack bus between one master and the arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

`ifndef SL_BYTE
`define SL_BYTE 2'b00
`endif
`ifndef SL_HALF
`define SL_HALF 2'b01
`endif
`ifndef SL_WORD
`define SL_WORD 2'b10
`endif

interface ram_port_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        bhw;
  logic [31:0]       wdata;
  logic              ack;
  logic              err;
  logic [31:0]       rdata;

  modport master (output req, we, addr, bhw, wdata, input ack, err, rdata);
  modport slave  (input req, we, addr, bhw, wdata, output ack, err, rdata);
endinterface

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// ram_port_arbiter : two-master round-robin sequencer for the data RAM port
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_port_arbiter #(
  parameter int RAM_WORDS = 64,
  parameter int ADDR_W    = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  ram_port_arbiter_if.slave   m0,
  ram_port_arbiter_if.slave   m1,
  output logic                ram_cs,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [1:0]          ram_bhw,
  output logic [31:0]         ram_wdata,
  input  logic [31:0]         ram_rdata,
  output logic                busy,
  output logic                last_gnt
);

  localparam logic [ADDR_W-3:0] LAST_WORD = (ADDR_W-2)'(RAM_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        bhw_q, bhw_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              last_gnt_q, last_gnt_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;

  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_bhw;
  logic [31:0]       sel_wdata;

  // Rejects unknown sizes and sub-word accesses that would run off the last word.
  function automatic logic is_illegal(input logic [1:0] bhw, input logic [ADDR_W-1:0] addr);
    logic in_last;
    in_last = (addr[ADDR_W-1:2] == LAST_WORD);
    case (bhw)
      `SL_BYTE: is_illegal = 1'b0;
      `SL_HALF: is_illegal = in_last && (addr[1:0] == 2'b11);
      `SL_WORD: is_illegal = in_last && (addr[1:0] != 2'b00);
      default:  is_illegal = 1'b1;
    endcase
  endfunction

  always_comb begin
    sel       = (m0.req && m1.req) ? prio_q : m1.req;
    sel_we    = sel ? m1.we    : m0.we;
    sel_addr  = sel ? m1.addr  : m0.addr;
    sel_bhw   = sel ? m1.bhw   : m0.bhw;
    sel_wdata = sel ? m1.wdata : m0.wdata;
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    gnt_d      = gnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    bhw_d      = bhw_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    last_gnt_d = last_gnt_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    case (state_q)
      S_IDLE: begin
        if (m0.req || m1.req) begin
          gnt_d   = sel;
          we_d    = sel_we;
          addr_d  = sel_addr;
          bhw_d   = sel_bhw;
          wdata_d = sel_wdata;
          err_d   = is_illegal(sel_bhw, sel_addr);
          state_d = is_illegal(sel_bhw, sel_addr) ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!we_q) begin
          if (gnt_q) rdata1_d = ram_rdata;
          else       rdata0_d = ram_rdata;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        prio_d     = ~gnt_q;
        last_gnt_d = gnt_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      prio_q     <= 1'b0;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      bhw_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      last_gnt_q <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      gnt_q      <= gnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      bhw_q      <= bhw_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      last_gnt_q <= last_gnt_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign ram_cs    = (state_q == S_ACCESS);
  assign ram_we    = ram_cs && we_q;
  assign ram_addr  = addr_q;
  assign ram_bhw   = bhw_q;
  assign ram_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign last_gnt  = last_gnt_q;

  assign m0.ack   = (state_q == S_RESP) && !gnt_q;
  assign m1.ack   = (state_q == S_RESP) &&  gnt_q;
  assign m0.err   = m0.ack && err_q;
  assign m1.err   = m1.ack && err_q;
  assign m0.rdata = rdata0_q;
  assign m1.rdata = rdata1_q;

endmodule

`default_nettype wire
